// File: rtl/scr1_dmem2wb_if.sv
// Signal bundle between the SCR1 data-memory port and the data-side
// Wishbone classic master port. The bridge uses the master modport and the
// environment (core model plus Wishbone slave) uses the slave modport.
interface scr1_dmem2wb_if;
  // Core data-memory side
  logic        core2dmem_req_i;
  logic        dmem2core_req_ack_o;
  logic        core2dmem_cmd_i;
  logic [1:0]  core2dmem_width_i;
  logic [31:0] core2dmem_addr_i;
  logic [31:0] core2dmem_wdata_i;
  logic [31:0] dmem2core_rdata_o;
  logic [1:0]  dmem2core_resp_o;
  // Wishbone classic side
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_ack_i;

  modport master (
    input  core2dmem_req_i, core2dmem_cmd_i, core2dmem_width_i,
           core2dmem_addr_i, core2dmem_wdata_i, wbm_dat_i, wbm_ack_i,
    output dmem2core_req_ack_o, dmem2core_rdata_o, dmem2core_resp_o,
           wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
  );

  modport slave (
    output core2dmem_req_i, core2dmem_cmd_i, core2dmem_width_i,
           core2dmem_addr_i, core2dmem_wdata_i, wbm_dat_i, wbm_ack_i,
    input  dmem2core_req_ack_o, dmem2core_rdata_o, dmem2core_resp_o,
           wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o
  );
endinterface

// File: rtl/scr1_dmem2wb.sv
// SCR1 data-memory port to Wishbone classic bridge. Each accepted core
// request becomes exactly one Wishbone cycle with byte-lane steering;
// misaligned/invalid requests and bus timeouts come back as ER responses.
module scr1_dmem2wb #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input logic            wb_clk_i,
  input logic            wb_rst_i,
  scr1_dmem2wb_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0]      RESP_IDLE = 2'd0;
  localparam logic [1:0]      RESP_RDY  = 2'd1;
  localparam logic [1:0]      RESP_ER   = 2'd2;
  // Last counter value of a waiting BUS cycle; the edge that ends it times out.
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_ONE   = TO_W'(1);

  state_e          state_q;
  state_e          state_d;
  logic            err_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            bad_req;
  logic [3:0]      sel_d;
  logic [31:0]     dat_d;
  logic            timeout_hit;

  // Decode width/address of the incoming request into lane select, steered
  // write data and the misaligned/invalid flag.
  // NOTE: every output gets a default before the case so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    bad_req = 1'b0;
    sel_d   = 4'b0000;
    dat_d   = bus.core2dmem_wdata_i;
    unique case (bus.core2dmem_width_i)
      2'd0: begin
        sel_d = 4'b0001 << bus.core2dmem_addr_i[1:0];
        dat_d = {4{bus.core2dmem_wdata_i[7:0]}};
      end
      2'd1: begin
        bad_req = bus.core2dmem_addr_i[0];
        sel_d   = bus.core2dmem_addr_i[1] ? 4'b1100 : 4'b0011;
        dat_d   = {2{bus.core2dmem_wdata_i[15:0]}};
      end
      2'd2: begin
        bad_req = |bus.core2dmem_addr_i[1:0];
        sel_d   = 4'b1111;
      end
      default: bad_req = 1'b1;
    endcase
  end

  // Ack has priority over a coincident timeout.
  assign timeout_hit = (TIMEOUT != 0) && !bus.wbm_ack_i && (to_cnt_q == TO_LAST);

  assign bus.dmem2core_req_ack_o = (state_q == ST_IDLE) && !wb_rst_i;
  assign bus.dmem2core_resp_o    = (state_q != ST_RESP) ? RESP_IDLE :
                                   (err_q ? RESP_ER : RESP_RDY);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.core2dmem_req_i) state_d = bad_req ? ST_RESP : ST_BUS;
      ST_BUS:  if (bus.wbm_ack_i || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, registered Wishbone outputs, timeout counter and read data.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q               <= ST_IDLE;
      err_q                 <= 1'b0;
      to_cnt_q              <= '0;
      bus.dmem2core_rdata_o <= '0;
      bus.wbm_adr_o         <= '0;
      bus.wbm_dat_o         <= '0;
      bus.wbm_sel_o         <= '0;
      bus.wbm_we_o          <= 1'b0;
      bus.wbm_stb_o         <= 1'b0;
      bus.wbm_cyc_o         <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.core2dmem_req_i) begin
            err_q <= bad_req;
            if (!bad_req) begin
              bus.wbm_cyc_o <= 1'b1;
              bus.wbm_stb_o <= 1'b1;
              bus.wbm_we_o  <= bus.core2dmem_cmd_i;
              bus.wbm_adr_o <= {bus.core2dmem_addr_i[31:2], 2'b00};
              bus.wbm_sel_o <= sel_d;
              bus.wbm_dat_o <= dat_d;
              to_cnt_q      <= '0;
            end
          end
        end
        ST_BUS: begin
          if (bus.wbm_ack_i) begin
            if (!bus.wbm_we_o) bus.dmem2core_rdata_o <= bus.wbm_dat_i;
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.wbm_we_o  <= 1'b0;
            err_q         <= 1'b0;
          end else if (timeout_hit) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            err_q         <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_dmem2wb.sv
// Bench for scr1_dmem2wb: a transaction-level model predicts every output
// each cycle, and directed transactions pin literal expectations.
module tb_scr1_dmem2wb;
  localparam int TIMEOUT = 4;
  localparam logic [1:0] R_IDLE = 2'd0, R_RDY = 2'd1, R_ER = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scr1_dmem2wb_if bus ();

  scr1_dmem2wb #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_bad(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'd3) return 1'b1;
    return (a % (32'd1 << w)) != 0;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] w, input logic [31:0] a);
    int s;
    s = ((1 << (1 << w)) - 1) << (a % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] w, input logic [31:0] d);
    int nb;
    logic [31:0] mask, r;
    nb   = 1 << w;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    r    = '0;
    for (int i = 0; i < 4; i += nb) r |= (d & mask) << (8 * i);
    return r;
  endfunction

  bit          m_bus = 0;
  logic [1:0]  m_resp = R_IDLE;
  logic        m_we = 0;
  logic [31:0] m_rdata = '0, m_adr = '0, m_dat = '0;
  logic [3:0]  m_sel = '0;
  int          m_wait = 0;
  bit          mon_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_bus = 0; m_resp = R_IDLE; m_we = 0; m_rdata = '0; m_wait = 0;
    end else if (m_resp != R_IDLE) begin
      m_resp = R_IDLE;
    end else if (m_bus) begin
      m_wait++;
      if (bus.wbm_ack_i) begin
        if (!m_we) m_rdata = bus.wbm_dat_i;
        m_bus = 0; m_we = 0; m_resp = R_RDY;
      end else if (TIMEOUT > 0 && m_wait >= TIMEOUT) begin
        m_bus = 0; m_resp = R_ER;
      end
    end else if (bus.core2dmem_req_i) begin
      if (is_bad(bus.core2dmem_width_i, bus.core2dmem_addr_i)) begin
        m_resp = R_ER;
      end else begin
        m_bus  = 1; m_wait = 0;
        m_we   = bus.core2dmem_cmd_i;
        m_adr  = bus.core2dmem_addr_i & 32'hFFFF_FFFC;
        m_sel  = lane_sel(bus.core2dmem_width_i, bus.core2dmem_addr_i);
        m_dat  = lane_data(bus.core2dmem_width_i, bus.core2dmem_wdata_i);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("cyc", {31'd0, bus.wbm_cyc_o}, {31'd0, m_bus});
      check("stb", {31'd0, bus.wbm_stb_o}, {31'd0, m_bus});
      check("we", {31'd0, bus.wbm_we_o}, {31'd0, m_we});
      check("resp", {30'd0, bus.dmem2core_resp_o}, {30'd0, m_resp});
      check("req_ack", {31'd0, bus.dmem2core_req_ack_o},
            {31'd0, (!rst && !m_bus && m_resp == R_IDLE)});
      check("rdata", bus.dmem2core_rdata_o, m_rdata);
      if (m_bus) begin
        check("adr", bus.wbm_adr_o, m_adr);
        check("sel", {28'd0, bus.wbm_sel_o}, {28'd0, m_sel});
        check("dat_o", bus.wbm_dat_o, m_dat);
      end
    end
  end

  // ---------------- Wishbone slave ----------------
  int          slave_wait = 0;   // stb cycles before the ack cycle; -1 never acks
  logic [31:0] slave_rdata = '0;
  bit          stray_ack = 0;
  int          stb_cnt = 0;
  logic [31:0] seen_adr = '0, seen_dat = '0;
  logic [3:0]  seen_sel = '0;
  logic        seen_we = 0;

  initial begin
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;
    bus.core2dmem_req_i   = 1'b0;
    bus.core2dmem_cmd_i   = 1'b0;
    bus.core2dmem_width_i = 2'd0;
    bus.core2dmem_addr_i  = '0;
    bus.core2dmem_wdata_i = '0;
  end

  always begin
    @(negedge clk);
    #1;
    if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
      stb_cnt++;
      seen_adr = bus.wbm_adr_o; seen_dat = bus.wbm_dat_o;
      seen_sel = bus.wbm_sel_o; seen_we  = bus.wbm_we_o;
      bus.wbm_ack_i = (slave_wait >= 0) && (stb_cnt > slave_wait);
    end else begin
      bus.wbm_ack_i = stray_ack;
    end
    bus.wbm_dat_i = bus.wbm_ack_i ? slave_rdata : (32'hBAD0_0000 ^ stb_cnt);
  end

  // ---------------- driver ----------------
  // Issues one request, then scrambles the core inputs after the accept edge;
  // returns the first non-IDLE response and its cycle number (accept = 0).
  task automatic txn(input string tag, input logic cmd, input logic [1:0] width,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int wait_cycles, input logic [31:0] sdata,
                     output logic [1:0] resp, output int lat);
    int guard;
    @(negedge clk);
    #1;
    slave_wait = wait_cycles; slave_rdata = sdata; stb_cnt = 0;
    bus.core2dmem_req_i = 1'b1; bus.core2dmem_cmd_i = cmd;
    bus.core2dmem_width_i = width; bus.core2dmem_addr_i = addr;
    bus.core2dmem_wdata_i = wdata;
    guard = 0;
    while (!bus.dmem2core_req_ack_o && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check({tag, " req_ack wait"}, {31'd0, guard < 20}, 32'd1);
    @(posedge clk);
    lat = 0;
    resp = R_IDLE;
    do begin
      @(negedge clk);
      lat++;
      resp = bus.dmem2core_resp_o;
      if (lat == 1) begin
        #1;
        bus.core2dmem_req_i = 1'b0; bus.core2dmem_cmd_i = ~cmd;
        bus.core2dmem_width_i = ~width; bus.core2dmem_addr_i = ~addr;
        bus.core2dmem_wdata_i = ~wdata;
      end
    end while (resp == R_IDLE && lat < 20);
  endtask

  logic [1:0] r;
  int         lat;

  initial begin
    repeat (3) @(posedge clk);
    mon_en = 1;
    @(negedge clk);
    // Reset state, literal.
    check("rst cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
    check("rst resp", {30'd0, bus.dmem2core_resp_o}, 32'd0);
    check("rst req_ack", {31'd0, bus.dmem2core_req_ack_o}, 32'd0);
    check("rst rdata", bus.dmem2core_rdata_o, 32'd0);
    check("rst adr/sel/dat", {bus.wbm_adr_o ^ bus.wbm_dat_o, 28'd0} | {28'd0, bus.wbm_sel_o}, 32'd0);
    #1 rst = 1'b0;

    // Word read, 2 wait cycles.
    txn("wr_read", 1'b0, 2'd2, 32'h0000_1004, 32'h0, 2, 32'hDEAD_BEEF, r, lat);
    check("wr_read resp", {30'd0, r}, {30'd0, R_RDY});
    check("wr_read lat", lat, 4);
    check("wr_read rdata", bus.dmem2core_rdata_o, 32'hDEAD_BEEF);
    check("wr_read adr", seen_adr, 32'h0000_1004);
    check("wr_read sel", {28'd0, seen_sel}, 32'hF);
    check("wr_read we", {31'd0, seen_we}, 32'd0);
    check("wr_read stb cycles", stb_cnt, 3);
    @(negedge clk);
    check("wr_read resp one cycle", {30'd0, bus.dmem2core_resp_o}, 32'd0);

    // Byte write, zero wait; rdata must not change.
    txn("bw", 1'b1, 2'd0, 32'h0000_2003, 32'h0000_00A5, 0, 32'h1111_1111, r, lat);
    check("bw resp", {30'd0, r}, {30'd0, R_RDY});
    check("bw lat", lat, 2);
    check("bw sel", {28'd0, seen_sel}, 32'h8);
    check("bw dat", seen_dat, 32'hA5A5_A5A5);
    check("bw we", {31'd0, seen_we}, 32'd1);
    check("bw stb cycles", stb_cnt, 1);
    check("bw rdata kept", bus.dmem2core_rdata_o, 32'hDEAD_BEEF);

    // Halfword write with upper junk in wdata.
    txn("hw", 1'b1, 2'd1, 32'h0000_2002, 32'hABCD_1234, 0, 32'h0, r, lat);
    check("hw resp", {30'd0, r}, {30'd0, R_RDY});
    check("hw sel", {28'd0, seen_sel}, 32'hC);
    check("hw dat", seen_dat, 32'h1234_1234);

    // Misaligned word, invalid width, misaligned halfword: no bus cycle.
    txn("mis_w", 1'b0, 2'd2, 32'h0000_3001, 32'h0, 0, 32'h0, r, lat);
    check("mis_w resp", {30'd0, r}, {30'd0, R_ER});
    check("mis_w lat", lat, 1);
    check("mis_w stb cycles", stb_cnt, 0);
    txn("inv_w", 1'b1, 2'd3, 32'h0000_3000, 32'h0, 0, 32'h0, r, lat);
    check("inv_w resp", {30'd0, r}, {30'd0, R_ER});
    check("inv_w stb cycles", stb_cnt, 0);
    txn("mis_h", 1'b0, 2'd1, 32'h0000_3003, 32'h0, 0, 32'h0, r, lat);
    check("mis_h resp", {30'd0, r}, {30'd0, R_ER});

    // Byte read: rdata is the raw bus word.
    txn("br", 1'b0, 2'd0, 32'h0000_0005, 32'h0, 1, 32'h0077_0000, r, lat);
    check("br sel", {28'd0, seen_sel}, 32'h2);
    check("br lat", lat, 3);
    check("br rdata", bus.dmem2core_rdata_o, 32'h0077_0000);

    // Timeout: slave never acks.
    txn("to", 1'b0, 2'd2, 32'h0000_4000, 32'h0, -1, 32'h0, r, lat);
    check("to resp", {30'd0, r}, {30'd0, R_ER});
    check("to stb cycles", stb_cnt, 4);
    check("to lat", lat, 5);
    check("to cyc low", {31'd0, bus.wbm_cyc_o}, 32'd0);

    // Ack on the timeout cycle: ack wins.
    txn("to_ack", 1'b0, 2'd2, 32'h0000_4004, 32'h0, 3, 32'hC0DE_0004, r, lat);
    check("to_ack resp", {30'd0, r}, {30'd0, R_RDY});
    check("to_ack lat", lat, 5);
    check("to_ack rdata", bus.dmem2core_rdata_o, 32'hC0DE_0004);

    txn("after_to", 1'b0, 2'd2, 32'h0000_4008, 32'h0, 0, 32'h5555_AAAA, r, lat);
    check("after_to resp", {30'd0, r}, {30'd0, R_RDY});

    // Stray ack while idle is ignored (model tracks every cycle).
    @(negedge clk);
    #1 stray_ack = 1;
    repeat (3) @(negedge clk);
    #1 stray_ack = 0;
    @(negedge clk);
    check("stray rdata", bus.dmem2core_rdata_o, 32'h5555_AAAA);

    // Reset during BUS: request dropped with no response.
    #1;
    slave_wait = -1; stb_cnt = 0;
    bus.core2dmem_req_i = 1'b1; bus.core2dmem_cmd_i = 1'b0;
    bus.core2dmem_width_i = 2'd2; bus.core2dmem_addr_i = 32'h0000_0040;
    @(negedge clk);
    #1 bus.core2dmem_req_i = 1'b0;
    @(negedge clk);
    check("rstmid cyc before", {31'd0, bus.wbm_cyc_o}, 32'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstmid cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
    check("rstmid stb", {31'd0, bus.wbm_stb_o}, 32'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid resp idle", {30'd0, bus.dmem2core_resp_o}, 32'd0);
    end
    txn("post_rst", 1'b0, 2'd2, 32'h0000_0044, 32'h0, 1, 32'h600D_F00D, r, lat);
    check("post_rst resp", {30'd0, r}, {30'd0, R_RDY});
    check("post_rst rdata", bus.dmem2core_rdata_o, 32'h600D_F00D);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/scr1_dmem2wb.md
# scr1_dmem2wb

Bridge between the SCR1 core data-memory port (req/req_ack/cmd/width/addr/wdata, rdata/resp) and one Wishbone classic master port. It sits directly between `scr1_core_top` DMEM outputs and the data-side Wishbone signals of the SCR1 wrapper. It converts each core request into a single Wishbone cycle with byte-lane steering. It also reports misalignment and bus timeouts to the core as error responses.

## Interface
Parameters:
- `TIMEOUT`, 255: max cycles `wbm_stb_o` may wait for ack before error; 0 disables timeout.
- `TO_W`, 8: width of timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- `wb_clk_i` in 1: single clock for all logic.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `core2dmem_req_i` in 1: core request valid.
- `dmem2core_req_ack_o` out 1: request accepted this cycle.
- `core2dmem_cmd_i` in 1: 0 = read, 1 = write.
- `core2dmem_width_i` in 2: 0 = byte, 1 = halfword, 2 = word, 3 = invalid.
- `core2dmem_addr_i` in 32: byte address.
- `core2dmem_wdata_i` in 32: right-aligned write data.
- `dmem2core_rdata_o` out 32: raw 32-bit bus word; valid when resp = RDY.
- `dmem2core_resp_o` out 2: 0 = IDLE, 1 = RDY, 2 = ER.
- `wbm_adr_o` out 32: word address `{addr[31:2],2'b00}`.
- `wbm_dat_o` out 32: steered write data.
- `wbm_dat_i` in 32: read data.
- `wbm_we_o` out 1: write enable.
- `wbm_sel_o` out 4: byte select.
- `wbm_stb_o` out 1: strobe.
- `wbm_cyc_o` out 1: cycle.
- `wbm_ack_i` in 1: slave acknowledge.

## Operation
- FSM states: IDLE, BUS, RESP.
- `dmem2core_req_ack_o` is combinational: 1 iff state = IDLE and `wb_rst_i` = 0.
- IDLE:
  - On req & req_ack, latch cmd/width/addr/wdata.
  - Misaligned (halfword with addr[0]=1, word with addr[1:0]≠0) or width=3: go to RESP with error flag set. No bus cycle.
  - Otherwise: go to BUS.
- Entering BUS registers the following, all held constant until exit:
  - `wbm_cyc_o` = `wbm_stb_o` = 1.
  - `wbm_we_o` = cmd.
  - `wbm_adr_o`.
  - `wbm_sel_o`:
    - byte: `4'b0001 << addr[1:0]`.
    - halfword: `4'b0011` if addr[1]=0, else `4'b1100`.
    - word: `4'b1111`.
  - `wbm_dat_o`:
    - byte: wdata[7:0] replicated to all 4 lanes.
    - halfword: wdata[15:0] replicated to both halves.
    - word: wdata.
- BUS exit:
  - ack=1: capture `wbm_dat_i` (reads only; writes keep previous rdata). Clear cyc/stb/we on the same edge. Go to RESP with error flag clear.
  - Timeout counter reaches TIMEOUT with no ack: clear cyc/stb. Go to RESP with error flag set.
- RESP: `dmem2core_resp_o` = ER if error flag set, else RDY, for exactly one cycle. Always returns to IDLE next.
- `dmem2core_resp_o` = IDLE in every other state.
- `dmem2core_rdata_o` holds its last captured value; it is not zeroed between transactions.
- `wbm_ack_i` is ignored outside BUS.
- Only one transaction is outstanding at a time; no pipelining or buffering.

## Timing
- Reset values: all Wishbone outputs 0, `dmem2core_rdata_o` = 0, resp = IDLE, req_ack = 0 while `wb_rst_i`=1, state IDLE, counter 0.
- Reset asserted mid-transaction: the next edge forces IDLE and drops cyc/stb. The pending request is discarded with no response.
- Cycle numbering, where cycle 0 is the accept edge (req & req_ack):
  - cyc/stb high from cycle 1.
  - Ack sampled at cycle k ≥ 1.
  - cyc/stb low from cycle k+1, with resp = RDY during cycle k+1.
  - req_ack high again in cycle k+2.
  - Minimum request-to-response: 2 cycles. Back-to-back throughput: one transaction per 3 cycles with zero-wait slaves.
- Misaligned or invalid request: resp = ER in cycle 1, req_ack high again in cycle 2.
- Timeout:
  - Counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT (TIMEOUT > 0): cyc/stb low in the following cycle, resp = ER in that cycle.
  - If ack and timeout coincide, ack wins and resp = RDY.
- Core inputs are sampled only on the accept edge; changes afterwards do not affect the cycle in progress.

## Test plan
- Word read: addr 0x0000_1004, slave acks with 0xDEAD_BEEF at 2-cycle wait → adr 0x0000_1004, sel 1111, we 0; resp RDY exactly one cycle with rdata 0xDEAD_BEEF.
- Byte write: addr 0x0000_2003, wdata 0x0000_00A5, zero-wait ack → sel 1000, dat_o 0xA5A5_A5A5, we 1; resp RDY; Wishbone cycle lasts 1 cycle.
- Halfword write: addr 0x0000_2002, wdata 0x1234 → sel 1100, dat_o 0x1234_1234.
- Misaligned word read: addr 0x0000_3001 → no cyc/stb at any cycle; resp ER one cycle after accept.
- Timeout with TIMEOUT=4 and slave never acks → stb high 4 cycles; resp ER on the cycle cyc drops; next request accepted and completes normally.
- Reset pulse during BUS → cyc/stb 0 after the edge; resp stays IDLE; a subsequent word read completes with RDY.
